// File: rtl/cronometro_pkg.sv
// Shared state codes and sizing helpers for the stopwatch control FSM.
package cronometro_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_LAP   = 3'd3,
    S_CLEAR = 3'd4,
    S_FULL  = 3'd5
  } state_t;

  localparam int TICK_DIV_DEF = 500000;

  function automatic int presc_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

  localparam int PRESC_W = presc_width(TICK_DIV_DEF);

endpackage

// File: rtl/cronometro_ctrl_btn_edge.sv
// Button synchronizer plus rising-edge detector.
// One single-cycle pulse per press; held buttons do not repeat.
module btn_edge (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  output logic PULSE
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= BTN;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign PULSE = s2 & ~s3;

endmodule

// File: rtl/cronometro_ctrl.sv
// Stopwatch control FSM: button sequencing, tick prescaler,
// clear pulse, lap freeze and full-scale saturation.
module cronometro_ctrl
  import cronometro_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int CLR_CYCLES = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               BTN_START,
  input  logic               BTN_LAP,
  input  logic               BTN_CLR,
  input  logic               CNT_MAX,
  output logic               CNT_EN,
  output logic               CNT_CLR,
  output logic               DISP_FREEZE,
  output logic               RUN_LED,
  output logic [STATE_W-1:0] STATE
);

  localparam int PW = presc_width(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  localparam int CW = $clog2(CLR_CYCLES + 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);

  state_t        state;
  state_t        nxt;
  logic [PW-1:0] presc;
  logic [CW-1:0] clr_cnt;
  logic          en_q;
  logic          start_p;
  logic          lap_p;
  logic          clr_p;
  logic          counting;
  logic          wrap;

  btn_edge u_start (
    .CLK  (CLK),
    .RST  (RST),
    .BTN  (BTN_START),
    .PULSE(start_p)
  );

  btn_edge u_lap (
    .CLK  (CLK),
    .RST  (RST),
    .BTN  (BTN_LAP),
    .PULSE(lap_p)
  );

  btn_edge u_clr (
    .CLK  (CLK),
    .RST  (RST),
    .BTN  (BTN_CLR),
    .PULSE(clr_p)
  );

  assign counting = (state == S_RUN) || (state == S_LAP);
  assign wrap     = counting && (presc == LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= nxt;
  end

  // Saturation outranks buttons; otherwise CLR > START > LAP.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (start_p) nxt = S_RUN;
      end
      S_RUN: begin
        if (wrap && CNT_MAX) nxt = S_FULL;
        else if (start_p)    nxt = S_PAUSE;
        else if (lap_p)      nxt = S_LAP;
      end
      S_LAP: begin
        if (wrap && CNT_MAX) nxt = S_FULL;
        else if (start_p)    nxt = S_PAUSE;
        else if (lap_p)      nxt = S_RUN;
      end
      S_PAUSE: begin
        if (clr_p)        nxt = S_CLEAR;
        else if (start_p) nxt = S_RUN;
      end
      S_FULL: begin
        if (clr_p) nxt = S_CLEAR;
      end
      S_CLEAR: begin
        if (clr_cnt == CLR_LAST) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    CNT_CLR     = 1'b0;
    DISP_FREEZE = 1'b0;
    RUN_LED     = 1'b0;
    unique case (1'b1)
      (state == S_CLEAR): CNT_CLR = 1'b1;
      (state == S_LAP): begin
        DISP_FREEZE = 1'b1;
        RUN_LED     = 1'b1;
      end
      (state == S_RUN): RUN_LED = 1'b1;
      default: ;
    endcase
  end

  assign STATE  = state;
  assign CNT_EN = en_q;

  // Prescaler holds in PAUSE so a partial tick survives the pause.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc   <= '0;
      clr_cnt <= '0;
      en_q    <= 1'b0;
    end else begin
      en_q <= wrap && !CNT_MAX;
      if (counting)
        presc <= wrap ? '0 : presc + 1'b1;
      else if (state != S_PAUSE)
        presc <= '0;
      clr_cnt <= (state == S_CLEAR) ? clr_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: doc/cronometro_ctrl.md
Name: cronometro_ctrl

Overview:
- Control FSM for the stopwatch counter chain (hundredths → seconds → minutes digit stages).
- Turns three debounced push-buttons (start/pause, lap, clear) into counter-chain sequencing: enable-tick generation from the system clock, clear pulses, display-freeze for lap, and saturation at full scale.
- Sits between the board buttons and the first digit stage; the digit stages ripple from CNT_EN.

Parameters:
- TICK_DIV, 500000, system clocks per counting tick (50 MHz / 100 Hz); must be >= 2.
- CLR_CYCLES, 2, number of cycles CNT_CLR is held during a clear; must be >= 1.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- BTN_START  in  1  start/pause button, debounced, asynchronous to CLK.
- BTN_LAP  in  1  lap button, debounced, asynchronous.
- BTN_CLR  in  1  clear button, debounced, asynchronous.
- CNT_MAX  in  1  high when the counter chain is at full scale (59:59.99).
- CNT_EN  out  1  one-cycle counting tick to the first digit stage.
- CNT_CLR  out  1  synchronous clear to all digit stages.
- DISP_FREEZE  out  1  hold the display latches (lap view).
- RUN_LED  out  1  high while counting (RUN or LAP).
- STATE  out  3  current FSM state code.

Behaviour:
- Reset, while RST high: STATE=IDLE, all outputs 0, prescaler 0, synchronizer flops 0. After release the FSM starts in IDLE.
- Button path: each button goes through a 2-flop synchronizer plus a registered rising-edge detector, giving one 1-cycle pulse per press. Held buttons produce no repeats.
- Latency: the FSM state changes on the 3rd rising CLK edge after the first edge that samples the button high.
- State codes: IDLE=0, RUN=1, PAUSE=2, LAP=3, CLEAR=4, FULL=5. Codes 6 and 7 are illegal and go to IDLE.
- Pulse priority when several arrive in the same cycle: CLR > START > LAP. Any pulse not valid in the current state is ignored.
- IDLE: START → RUN. LAP and CLR are ignored.
- RUN: START → PAUSE. LAP → LAP. CLR is ignored.
- LAP: counting continues with DISP_FREEZE=1. LAP → RUN (freeze drops). START → PAUSE (freeze drops). CLR is ignored.
- PAUSE: START → RUN. CLR → CLEAR. LAP is ignored.
- FULL: START and LAP are ignored. CLR → CLEAR.
- CLEAR: CNT_CLR=1 for exactly CLR_CYCLES cycles, then IDLE.
- Prescaler counts 0..TICK_DIV-1 and wraps. It counts only in RUN and LAP.
  - It holds its value in PAUSE, so partial ticks are kept across a pause.
  - It is forced to 0 in IDLE, CLEAR and FULL.
- CNT_EN is registered. It is 1 for one cycle in the cycle after the prescaler equals TICK_DIV-1 while counting, and CNT_MAX=0.
- Saturation: if the prescaler reaches TICK_DIV-1 while counting and CNT_MAX=1, no CNT_EN is issued and the next state is FULL (freeze drops).
- Pause at wrap: a START pulse in the same cycle as prescaler=TICK_DIV-1 still issues that tick. The prescaler wraps to 0 and the state becomes PAUSE.
- DISP_FREEZE=1 only in LAP. RUN_LED=1 only in RUN or LAP.
- Output timing: all outputs are registered or decoded only from registered state; no combinational path from inputs to outputs.
- RST asserted in any state, including mid-CLEAR: immediate return to the reset values. A CLEAR in progress is abandoned; the digit stages have their own reset.

Decomposition:
- Shared package cronometro_pkg holds:
  - state encodings IDLE..FULL and the STATE width (3);
  - the TICK_DIV default and the prescaler width, computed as clog2(TICK_DIV).
- Sub-module btn_edge holds the 2-flop synchronizer and edge detector (CLK, RST, BTN → PULSE). It is instantiated three times.

Test Plan:
- Sim parameters: TICK_DIV=4, CLR_CYCLES=2.
1. Reset then START press → STATE=1 three edges after sampling; CNT_EN pulses every 4 cycles; RUN_LED=1.
2. RUN, START after 2 prescaler counts, wait 20 cycles, START again → no CNT_EN while paused; first tick after resume arrives 2 cycles after re-entering RUN.
3. RUN, LAP → DISP_FREEZE=1 and CNT_EN continues every 4 cycles; LAP again → DISP_FREEZE=0, STATE=1.
4. PAUSE, CLR → STATE=4, CNT_CLR high exactly 2 cycles, then STATE=0 and prescaler 0. CLR pressed in RUN → ignored.
5. RUN with CNT_MAX=1 at prescaler=3 → no CNT_EN, STATE=5; START ignored; CLR → CLEAR → IDLE.
6. Same-cycle START+LAP in RUN → PAUSE (START wins). RST asserted mid-CLEAR → CNT_CLR=0 and STATE=0 immediately, without waiting for a CLK edge.
